// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one combinational ALU: IDLE -> EXEC -> RESP.
// Optional macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins ties and the last-grant pointer is removed.
module alu_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_ctrl,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_ctrl,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [3:0]       alu_ctrl,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_zero,
   input  logic             rsp_ready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   grant1;
   logic   accept;
   logic   handshake;
   logic   op_id;

`ifdef ALU_ARB_FIXED_PRIO_EN
   always_comb begin
      grant1 = req1_valid && !req0_valid;
   end
`else
   // last = 1 means requester 1 was granted last, so requester 0 wins the next tie.
   logic last;

   always_comb begin
      grant1 = req1_valid;
      if (req0_valid && req1_valid) begin
         grant1 = !last;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= 1'b1;
      end else if (handshake) begin
         last <= grant1;
      end
   end
`endif

   // Ready is gated by rst_n so it drops the instant reset is asserted.
   assign accept     = (state == IDLE) && rst_n;
   assign req0_ready = accept && req0_valid && !grant1;
   assign req1_ready = accept && req1_valid && grant1;
   assign handshake  = req0_ready || req1_ready;
   assign rsp_valid  = (state == RESP);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (handshake) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Operand registers feed the ALU directly and simply hold outside EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_ctrl <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         op_id    <= 1'b0;
         rsp_id   <= 1'b0;
         rsp_data <= '0;
         rsp_zero <= 1'b0;
      end else begin
         if (handshake) begin
            alu_ctrl <= grant1 ? req1_ctrl : req0_ctrl;
            alu_a    <= grant1 ? req1_a    : req0_a;
            alu_b    <= grant1 ? req1_b    : req0_b;
            op_id    <= grant1;
         end
         if (state == EXEC) begin
            rsp_data <= alu_result;
            rsp_zero <= alu_zero;
            rsp_id   <= op_id;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_alu_arbiter;
   localparam int WIDTH = 32;
`ifdef ALU_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req0_valid, req1_valid, req0_ready, req1_ready;
   logic [3:0]       req0_ctrl, req1_ctrl, alu_ctrl;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, rsp_data;
   logic             alu_zero, rsp_valid, rsp_id, rsp_zero, rsp_ready;
   int               total = 0;
   int               bad = 0;

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] ref_alu(input logic [3:0] c, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      case (c)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0111: return ($signed(a) < $signed(b)) ? 1 : 0;
         4'b1100: return ~(a | b);
         default: return '0;
      endcase
   endfunction

   // Shared ALU seen by the arbiter.
   assign alu_result = ref_alu(alu_ctrl, alu_a, alu_b);
   assign alu_zero   = (alu_result == '0);

   alu_arbiter #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
      .req1_a(req1_a), .req1_b(req1_b),
      .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
      .rsp_ready(rsp_ready)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_ctrl = 4'b0010; req1_ctrl = 4'b0110;
      req0_a = 1; req0_b = 2; req1_a = 3; req1_b = 4;
      rsp_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++;
         $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready); end
      total++; if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_zero !== 1'b0) begin bad++;
         $display("FAIL reset_rsp_flags: got v=%b id=%b z=%b want 0 0 0", rsp_valid, rsp_id, rsp_zero); end
      total++; if (rsp_data !== '0) begin bad++;
         $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
      total++; if (alu_ctrl !== 4'd0 || alu_a !== '0 || alu_b !== '0) begin bad++;
         $display("FAIL reset_alu: got %h %h %h want 0 0 0", alu_ctrl, alu_a, alu_b); end
      tick;
      tick;
      rst_n = 1'b1;
      #1;
      total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++;
         $display("FAIL reset_first_tie: got %b%b want 10", req0_ready, req1_ready); end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick;
   endtask

   task automatic test_single_add;
      req0_valid = 1'b1; req0_ctrl = 4'b0010; req0_a = 5; req0_b = 7;
      #1;
      total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || rsp_valid !== 1'b0) begin bad++;
         $display("FAIL add_cycle0: got r=%b%b v=%b want 10 0", req0_ready, req1_ready, rsp_valid); end
      tick;
      req0_valid = 1'b0;
      #1;
      total++; if (rsp_valid !== 1'b0 || alu_ctrl !== 4'b0010 || alu_a !== 5 || alu_b !== 7) begin bad++;
         $display("FAIL add_exec: got v=%b alu=%h %0d %0d want 0 2 5 7", rsp_valid, alu_ctrl, alu_a, alu_b); end
      tick;
      total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 12 || rsp_zero !== 1'b0) begin bad++;
         $display("FAIL add_resp: got v=%b id=%b d=%0d z=%b want 1 0 12 0", rsp_valid, rsp_id, rsp_data, rsp_zero); end
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      total++; if (rsp_valid !== 1'b0 || alu_a !== 5 || alu_b !== 7) begin bad++;
         $display("FAIL add_after: got v=%b a=%0d b=%0d want 0 5 7", rsp_valid, alu_a, alu_b); end
   endtask

   task automatic test_zero_flag;
      req1_valid = 1'b1; req1_ctrl = 4'b0110; req1_a = 9; req1_b = 9;
      #1;
      total++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin bad++;
         $display("FAIL zero_grant: got %b%b want 01", req0_ready, req1_ready); end
      tick;
      req1_valid = 1'b0;
      tick;
      total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 0 || rsp_zero !== 1'b1) begin bad++;
         $display("FAIL zero_resp: got v=%b id=%b d=%0d z=%b want 1 1 0 1", rsp_valid, rsp_id, rsp_data, rsp_zero); end
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
   endtask

   task automatic test_contention;
      int grants[4];
      int when[4];
      int n = 0;
      req0_valid = 1'b1; req0_ctrl = 4'b0010; req0_a = 100; req0_b = 3;
      req1_valid = 1'b1; req1_ctrl = 4'b0110; req1_a = 50;  req1_b = 8;
      rsp_ready = 1'b1;
      for (int c = 0; c < 40 && n < 4; c++) begin
         #1;
         if (req0_ready) begin grants[n] = 0; when[n] = c; n++; end
         else if (req1_ready) begin grants[n] = 1; when[n] = c; n++; end
         tick;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      total++; if (n !== 4) begin bad++;
         $display("FAIL contention_count: got %0d grants want 4", n); end
      for (int i = 0; i < n; i++) begin
         total++; if (grants[i] !== (FIXED ? 0 : i % 2)) begin bad++;
            $display("FAIL contention_grant%0d: got %0d want %0d", i, grants[i], FIXED ? 0 : i % 2); end
         if (i > 0) begin
            total++; if (when[i] - when[i-1] !== 3) begin bad++;
               $display("FAIL contention_interval%0d: got %0d want 3", i, when[i] - when[i-1]); end
         end
      end
      repeat (4) tick;
      rsp_ready = 1'b0;
   endtask

   task automatic test_backpressure;
      req0_valid = 1'b1; req0_ctrl = 4'b0001; req0_a = 32'hF0F0_0000; req0_b = 32'h0000_0F0F;
      tick;
      req0_valid = 1'b0;
      tick;
      req0_valid = 1'b1; req0_ctrl = 4'b0010; req0_a = 1; req0_b = 1;
      req1_valid = 1'b1; req1_ctrl = 4'b0010; req1_a = 2; req1_b = 2;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hF0F0_0F0F || alu_a !== 32'hF0F0_0000) begin bad++;
            $display("FAIL bp_hold%0d: got v=%b d=%h a=%h want 1 f0f00f0f f0f00000", i, rsp_valid, rsp_data, alu_a); end
         total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++;
            $display("FAIL bp_ready%0d: got %b%b want 00", i, req0_ready, req1_ready); end
         tick;
      end
      rsp_ready = 1'b1;
      #1;
      total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp_valid !== 1'b1) begin bad++;
         $display("FAIL bp_release: got r=%b%b v=%b want 00 1", req0_ready, req1_ready, rsp_valid); end
      tick;
      rsp_ready = 1'b0;
      #1;
      total++; if (req0_ready !== FIXED || req1_ready !== !FIXED) begin bad++;
         $display("FAIL bp_regrant: got %b%b want %b%b", req0_ready, req1_ready, FIXED, !FIXED); end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick;
   endtask

   task automatic test_reset_mid_exec;
      req0_valid = 1'b1; req0_ctrl = 4'b0010; req0_a = 32'h1234; req0_b = 32'h1;
      tick;
      req0_valid = 1'b0;
      #1;
      total++; if (alu_a !== 32'h1234) begin bad++;
         $display("FAIL rst_exec_alu: got %h want 1234", alu_a); end
      rst_n = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      total++; if (rsp_valid !== 1'b0 || rsp_data !== '0 || alu_a !== '0 || alu_b !== '0 || alu_ctrl !== 4'd0) begin bad++;
         $display("FAIL rst_exec_clear: got v=%b d=%h alu=%h %h %h want all 0", rsp_valid, rsp_data, alu_ctrl, alu_a, alu_b); end
      total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++;
         $display("FAIL rst_exec_ready: got %b%b want 00", req0_ready, req1_ready); end
      tick;
      rst_n = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++; if (rsp_valid !== 1'b0) begin bad++;
            $display("FAIL rst_exec_norsp%0d: got %b want 0", i, rsp_valid); end
         tick;
      end
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++;
         $display("FAIL rst_exec_tie: got %b%b want 10", req0_ready, req1_ready); end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick;
   endtask

   // Transaction model: an accepted op owns the ALU on the next cycle and answers from the cycle after.
   task automatic test_random;
      logic [3:0]       ops[6];
      bit               busy = 1'b0;
      int               since = 0;
      bit               pend0 = 1'b0, pend1 = 1'b0;
      bit               pref1 = 1'b0;
      bit               e0, e1, ev;
      logic [3:0]       mc;
      logic [WIDTH-1:0] ma, mb, mres;
      bit               mid = 1'b0;
      ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
      mc = '0; ma = '0; mb = '0;
      for (int c = 0; c < 600; c++) begin
         if (!pend0 && $urandom_range(0, 1) == 1) begin
            pend0 = 1'b1; req0_ctrl = ops[$urandom_range(0, 5)];
            req0_a = $urandom; req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
         end
         if (!pend1 && $urandom_range(0, 1) == 1) begin
            pend1 = 1'b1; req1_ctrl = ops[$urandom_range(0, 5)];
            req1_a = $urandom; req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
         end
         req0_valid = pend0; req1_valid = pend1;
         rsp_ready = ($urandom_range(0, 2) != 0);
         #1;
         ev = busy && since >= 2;
         e0 = 1'b0; e1 = 1'b0;
         if (!busy) begin
            if (pend0 && pend1) begin e1 = pref1; e0 = !pref1; end
            else begin e0 = pend0; e1 = pend1; end
         end
         total++; if (req0_ready !== e0 || req1_ready !== e1) begin bad++;
            $display("FAIL rnd_ready c=%0d: got %b%b want %b%b", c, req0_ready, req1_ready, e0, e1); end
         total++; if (rsp_valid !== ev) begin bad++;
            $display("FAIL rnd_valid c=%0d: got %b want %b", c, rsp_valid, ev); end
         if (ev) begin
            mres = ref_alu(mc, ma, mb);
            total++; if (rsp_id !== mid || rsp_data !== mres || rsp_zero !== (mres == '0)) begin bad++;
               $display("FAIL rnd_rsp c=%0d: got id=%b d=%h z=%b want %b %h %b", c, rsp_id, rsp_data, rsp_zero,
                        mid, mres, (mres == '0)); end
         end
         if (busy && since == 1) begin
            total++; if (alu_ctrl !== mc || alu_a !== ma || alu_b !== mb) begin bad++;
               $display("FAIL rnd_alu c=%0d: got %h %h %h want %h %h %h", c, alu_ctrl, alu_a, alu_b, mc, ma, mb); end
         end
         if (busy) begin
            if (since >= 2 && rsp_ready) busy = 1'b0;
            else since++;
         end else if (e0 || e1) begin
            busy = 1'b1; since = 1; mid = e1;
            mc = e1 ? req1_ctrl : req0_ctrl;
            ma = e1 ? req1_a : req0_a;
            mb = e1 ? req1_b : req0_b;
            if (e1) pend1 = 1'b0; else pend0 = 1'b0;
            pref1 = FIXED ? 1'b0 : !e1;
         end
         tick;
      end
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
   endtask

   initial begin
      test_reset;
      test_single_add;
      test_zero_flag;
      test_contention;
      test_backpressure;
      test_reset_mid_exec;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester has an ALU operation pending.
REQ-005 req0_ready / req1_ready  output  1 each  operation accepted this cycle.
REQ-006 req0_ctrl / req1_ctrl  input  4 each  ALU control code, same encoding alu_control produces (0010 add, 0110 sub, ...).
REQ-007 req0_a, req0_b / req1_a, req1_b  input  WIDTH each  operands.
REQ-008 alu_ctrl  output  4  control code driven to the shared ALU.
REQ-009 alu_a, alu_b  output  WIDTH each  operands driven to the shared ALU.
REQ-010 alu_result  input  WIDTH  combinational ALU result; alu_zero  input  1  ALU zero flag.
REQ-011 rsp_valid  output  1  response held; rsp_id  output  1  owning requester (0/1).
REQ-012 rsp_data  output  WIDTH  captured result; rsp_zero  output  1  captured zero flag.
REQ-013 rsp_ready  input  1  requester consumes the response.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC, RESP.
REQ-015 reqN_ready SHALL be high only in IDLE, and only for the granted requester with reqN_valid high; at most one ready high per cycle.
REQ-016 Handshake (valid & ready) SHALL register ctrl, a, b and requester id, and move IDLE->EXEC.
REQ-017 In EXEC, alu_ctrl/alu_a/alu_b SHALL come from those registers; at cycle end, alu_result/alu_zero SHALL be captured into rsp_data/rsp_zero, and the FSM SHALL go to RESP.
REQ-018 Outside EXEC, alu_ctrl, alu_a and alu_b SHALL hold their last registered values; the ALU is not owned.
REQ-019 In RESP, rsp_valid SHALL be 1 with rsp_id/rsp_data/rsp_zero stable until rsp_ready=1; then the FSM SHALL go to IDLE next edge.
REQ-020 Latency: rsp_valid SHALL rise exactly 2 cycles after the handshake edge; minimum issue interval 3 cycles.
REQ-021 Requests SHALL be ignored (no ready) in EXEC and RESP; requesters hold valid and payload until ready.
REQ-022 Round-robin: with both valid in IDLE, the requester not granted last SHALL win; a lone valid requester SHALL be granted regardless of history.
REQ-023 The last-grant pointer SHALL update only on a handshake.
REQ-024 rsp_ready while rsp_valid=0 SHALL be ignored.
REQ-025 Operands SHALL pass unmodified; no width conversion.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, both ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=0, alu_ctrl=0, alu_a=0, alu_b=0, last-grant=1 (requester 0 wins first tie).
REQ-027 Reset during EXEC or RESP SHALL discard the in-flight operation; no response is produced after deassertion.
REQ-028 Deassertion SHALL take effect at the next rising clk edge; the first grant is possible in that cycle.

Configuration
REQ-029 Macro ALU_ARB_FIXED_PRIO_EN: defined -> requester 0 SHALL always win ties, and the last-grant pointer is removed.
REQ-030 Macro undefined -> round-robin per REQ-022/023.

Verification
REQ-031 Single add: req0 ctrl=0010 a=5 b=7 -> req0_ready in cycle 0, rsp_valid in cycle 2, rsp_id=0, rsp_data=12, rsp_zero=0.
REQ-032 Zero flag: req1 ctrl=0110 a=9 b=9 -> rsp_id=1, rsp_data=0, rsp_zero=1.
REQ-033 Contention: both valid for 4 ops, rsp_ready=1 -> grants 0,1,0,1 (macro undefined); 0,0,0,0 with ALU_ARB_FIXED_PRIO_EN while req0 stays valid.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stable, both ready=0; ready returns 1 cycle after rsp_ready=1.
REQ-035 Reset mid-EXEC: rst_n low 1 cycle during EXEC -> all outputs 0 at once, no rsp_valid afterwards, the next tie grants req0.
